// File: rtl/mem_word_ctrl_pkg.sv
// Shared definitions for the word-access controller and the byte-wide RAM bus.
// Byte width, address width, RAM depth and the controller state encoding.
package mem_word_ctrl_pkg;

  localparam int BYTE  = 8;
  localparam int NBITS = 8;
  localparam int WORDS = 256;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_TAIL,
    DONE
  } mem_ctrl_state_t;

  // Byte address of lane `off` of a word starting at `base`; wraps modulo 2**NBITS.
  function automatic logic [NBITS-1:0] byte_addr(input logic [NBITS-1:0] base,
                                                 input int unsigned off);
    return base + NBITS'(off);
  endfunction

endpackage

// File: rtl/mem_word_ctrl_if.sv
// Byte-wide RAM bus: one master drives the write enable, data and address,
// and the RAM returns its registered read data on q.
interface ram_bus
  import mem_word_ctrl_pkg::*;
  ;

  logic             we;
  logic [BYTE-1:0]  data;
  logic [NBITS-1:0] addr;
  logic [BYTE-1:0]  q;

  modport master (output we, output data, output addr, input q);
  modport slave  (input we, input data, input addr, output q);

endinterface

// File: rtl/ram.sv
// Byte-wide single-port RAM with a one-cycle registered read; the read
// returns the contents before any write on the same edge.
module ram
  import mem_word_ctrl_pkg::*;
(
  input logic    clk,
  ram_bus.slave  bus
);

  logic [BYTE-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[bus.addr] <= bus.data;
    end
    bus.q <= mem[bus.addr];
  end

endmodule

// File: rtl/mem_word_ctrl.sv
// Sequences one multi-byte little-endian load or store into consecutive byte
// accesses on the RAM bus, hiding the RAM's one-cycle read latency.
module mem_word_ctrl
  import mem_word_ctrl_pkg::*;
#(
  parameter  int WORD_BYTES = 4,
  localparam int WB         = WORD_BYTES * BYTE,
  localparam int CW         = $clog2(WORD_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wr,
  input  logic [NBITS-1:0] addr,
  input  logic [WB-1:0]    wdata,
  output logic             ready,
  output logic             done,
  output logic [WB-1:0]    rdata,
  ram_bus.master           bus
);

  localparam logic [CW-1:0] LAST = CW'(WORD_BYTES - 1);

  mem_ctrl_state_t  state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NBITS-1:0] base_reg, base_next;
  logic [WB-1:0]    wdata_reg, wdata_next;
  logic [WB-1:0]    rdata_reg, rdata_next;
  logic             we_reg, we_next;
  logic [NBITS-1:0] baddr_reg, baddr_next;
  logic [BYTE-1:0]  bdata_reg, bdata_next;

  // Bus outputs are registered: each edge loads the values for the next cycle,
  // so reset clears the write enable without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      base_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      we_reg    <= 1'b0;
      baddr_reg <= '0;
      bdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      base_reg  <= base_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      we_reg    <= we_next;
      baddr_reg <= baddr_next;
      bdata_reg <= bdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    base_next  = base_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    we_next    = we_reg;
    baddr_next = baddr_reg;
    bdata_next = bdata_reg;

    case (state_reg)
      IDLE: begin
        if (req) begin
          base_next  = addr;
          wdata_next = wdata;
          cnt_next   = '0;
          baddr_next = addr;
          if (wr) begin
            state_next = WR;
            we_next    = 1'b1;
            bdata_next = wdata[BYTE-1:0];
          end else begin
            state_next = RD;
            we_next    = 1'b0;
          end
        end
      end

      WR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = DONE;
          we_next    = 1'b0;
        end else begin
          baddr_next = byte_addr(base_reg, int'(cnt_reg) + 1);
          bdata_next = wdata_reg[(int'(cnt_reg) + 1) * BYTE +: BYTE];
        end
      end

      RD: begin
        cnt_next = cnt_reg + 1'b1;
        // q now holds the byte whose address was presented one cycle earlier.
        if (cnt_reg != '0) begin
          rdata_next[(int'(cnt_reg) - 1) * BYTE +: BYTE] = bus.q;
        end
        if (cnt_reg == LAST) begin
          state_next = RD_TAIL;
        end else begin
          baddr_next = byte_addr(base_reg, int'(cnt_reg) + 1);
        end
      end

      RD_TAIL: begin
        rdata_next[(WORD_BYTES - 1) * BYTE +: BYTE] = bus.q;
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        we_next    = 1'b0;
      end
    endcase
  end

  assign ready    = (state_reg == IDLE);
  assign done     = (state_reg == DONE);
  assign rdata    = rdata_reg;
  assign bus.we   = we_reg;
  assign bus.addr = baddr_reg;
  assign bus.data = bdata_reg;

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Directed bench for mem_word_ctrl with a 4-byte word against the byte RAM.
module tb_mem_word_ctrl;
  import mem_word_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  ram_bus bus ();

  ram u_ram (
    .clk (clk),
    .bus (bus)
  );

  mem_word_ctrl #(.WORD_BYTES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .rdata (rdata),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Issue one access from a negedge; waits for ready, returns edges from the
  // accept edge to the done cycle (-1 if done never appears) and rdata then.
  task automatic do_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd);
    int g;
    lat = -1;
    rd  = 'x;
    req = 1'b1; wr = w; addr = a; wdata = d;
    g = 0;
    while (ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        rd  = rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 32'h0;
    #12;
    rst = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    n_cmp++; if (bus.we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.we); end
    n_cmp++; if (bus.addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", bus.addr); end
    n_cmp++; if (bus.data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.data); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL release_done: got %b want 0", done); end
    $display("reset: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_store_load();
    int lat;
    logic [31:0] rd;
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_access(1'b1, 8'h10, 32'hDEADBEEF, lat, rd);
    $display("store 0x10 <= deadbeef latency=%0d", lat);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL store_latency: got %0d want 4", lat); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (u_ram.mem[8'(8'h10 + i)] !== exp_b[i]) begin
        n_bad++; $display("FAIL store_byte%0d: got %h want %h", i, u_ram.mem[8'(8'h10 + i)], exp_b[i]);
      end
    end
    do_access(1'b0, 8'h10, 32'h0, lat, rd);
    $display("load  0x10 => %h latency=%0d", rd, lat);
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL load_latency: got %0d want 5", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] rd;
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    do_access(1'b1, 8'hFE, 32'h11223344, lat, rd);
    $display("store 0xfe <= 11223344 latency=%0d", lat);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (u_ram.mem[exp_a[i]] !== exp_b[i]) begin
        n_bad++; $display("FAIL wrap_byte%0d: got %h want %h", i, u_ram.mem[exp_a[i]], exp_b[i]);
      end
    end
    do_access(1'b0, 8'hFE, 32'h0, lat, rd);
    $display("load  0xfe => %h latency=%0d", rd, lat);
    n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL wrap_load: got %h want 11223344", rd); end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL wrap_latency: got %0d want 5", lat); end
  endtask

  task automatic test_busy();
    int lat;
    int base;
    logic [31:0] rd;
    logic [7:0] exp_b [4];
    exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    do_access(1'b1, 8'h80, 32'h5A5A5A5A, lat, rd);
    @(negedge clk);
    base = done_cnt;
    req = 1'b1; wr = 1'b1; addr = 8'h60; wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", ready); end
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 8'h80; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    $display("busy store 0x60 <= cafef00d with ignored req to 0x80, dones=%0d", done_cnt - base);
    n_cmp++; if (done_cnt - base != 1) begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (u_ram.mem[8'(8'h80 + i)] !== 8'h5A) begin
        n_bad++; $display("FAIL busy_untouched%0d: got %h want 5a", i, u_ram.mem[8'(8'h80 + i)]);
      end
      n_cmp++;
      if (u_ram.mem[8'(8'h60 + i)] !== exp_b[i]) begin
        n_bad++; $display("FAIL busy_store%0d: got %h want %h", i, u_ram.mem[8'(8'h60 + i)], exp_b[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rd;
    do_access(1'b1, 8'h24, 32'h99887766, lat, rd);
    do_access(1'b1, 8'h20, 32'h01020304, lat, rd);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL b2b_store_latency: got %0d want 4", lat); end
    do_access(1'b0, 8'h22, 32'h0, lat, rd);
    $display("load  0x22 after store => %h latency=%0d", rd, lat);
    n_cmp++; if (rd[15:0] !== 16'h0102) begin n_bad++; $display("FAIL hazard_new_bytes: got %h want 0102", rd[15:0]); end
    n_cmp++; if (rd[31:16] !== 16'h7766) begin n_bad++; $display("FAIL hazard_old_bytes: got %h want 7766", rd[31:16]); end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL hazard_latency: got %0d want 5", lat); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int base;
    logic [31:0] rd;
    logic [7:0] exp_b [4];
    exp_b = '{8'hDD, 8'hCC, 8'h66, 8'h55};
    do_access(1'b1, 8'h40, 32'h55667788, lat, rd);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 8'h40; wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.we !== 1'b1) begin n_bad++; $display("FAIL abort_pre_we: got %b want 1", bus.we); end
    base = done_cnt;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.we !== 1'b0) begin n_bad++; $display("FAIL abort_we: got %b want 0", bus.we); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", ready); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL abort_rdata: got %h want 00000000", rdata); end
    n_cmp++; if (bus.addr !== 8'h00) begin n_bad++; $display("FAIL abort_addr: got %h want 00", bus.addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    $display("aborted store 0x40 <= aabbccdd, dones=%0d", done_cnt - base);
    n_cmp++; if (done_cnt != base) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (u_ram.mem[8'(8'h40 + i)] !== exp_b[i]) begin
        n_bad++; $display("FAIL abort_byte%0d: got %h want %h", i, u_ram.mem[8'(8'h40 + i)], exp_b[i]);
      end
    end
    do_access(1'b0, 8'h40, 32'h0, lat, rd);
    $display("load  0x40 after abort => %h latency=%0d", rd, lat);
    n_cmp++; if (rd !== 32'h5566CCDD) begin n_bad++; $display("FAIL abort_reload: got %h want 5566ccdd", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_busy();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
